uart_tx_framer: RTL and testbench

Parametrised UART transmitter with a small transmit FIFO, selectable data width, parity and stop-bit count, and an internal baud divider. It is the next-generation drop-in for the sensor link's fixed 8N2 transmitter. It sits between the sensor-readout logic, which pushes bytes through a valid/ready handshake, and the FPGA TxD pin. Unlike the fixed transmitter, the producer can queue up to FIFO_DEPTH words and frames are sent back-to-back without idle gaps.

---
 rtl/uart_tx_framer.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmitter with transmit FIFO, configurable framing and baud divider
module uart_tx_framer #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          TxD,
    output logic                          TxD_busy
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

    generate
        if (DIV < 2) begin : g_chk_div
            $error("uart_tx_framer: baud divider must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
            $error("uart_tx_framer: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
            $error("uart_tx_framer: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
            $error("uart_tx_framer: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
            $error("uart_tx_framer: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // transmit FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] head;

    // framer
    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 txd_q, txd_d;
    logic                 tick;

    // a full FIFO refuses the push even when a pop frees a slot this same cycle
    assign tx_ready   = (level_q != LEVEL_MAX);
    assign push       = tx_valid & tx_ready;
    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign tx_level   = level_q;
    assign tick       = (baud_q == BAUD_LAST);
    assign TxD        = txd_q;
    assign TxD_busy   = (state_q != S_IDLE) || !fifo_empty;

    // FIFO storage; contents need no reset since the pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // framer state, baud counter, shifter and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
        end
    end

    // next-state: bit sequencing, frame chaining from STOP, and next line level
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;
        txd_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                pop = !fifo_empty;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        pop     = !fifo_empty;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // the counter only runs inside a frame and wraps on every bit tick
        if (state_q == S_IDLE || tick) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + CW'(1);
        end

        // a pop starts a fresh frame with the counter phase cleared
        if (pop) begin
            state_d  = S_START;
            shift_d  = head;
            parity_d = (PARITY == 1) ? ~(^head) : (^head);
            bit_d    = '0;
            baud_d   = '0;
        end

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - randomized self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

    localparam int DIV  = 10;
    localparam int FL_A = DIV * (1 + 8 + 0 + 1);
    localparam int FL_B = DIV * (1 + 7 + 1 + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_valid = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_ready, a_txd, a_busy;
    logic [2:0] a_level;

    logic       b_valid = 1'b0;
    logic [6:0] b_data = '0;
    logic       b_ready, b_txd, b_busy;
    logic [2:0] b_level;

    logic       c_valid = 1'b0;
    logic [6:0] c_data = '0;
    logic       c_ready, c_txd, c_busy;
    logic [2:0] c_level;

    logic [5:0] a_vec, b_vec, c_vec;
    assign a_vec = {a_txd, a_busy, a_ready, a_level};
    assign b_vec = {b_txd, b_busy, b_ready, b_level};
    assign c_vec = {c_txd, c_busy, c_ready, c_level};

    int checks = 0;
    int failures = 0;

    uart_tx_framer #(.CLK_FREQ(1000000), .BAUD(100000)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(a_valid), .tx_data(a_data),
        .tx_ready(a_ready), .tx_level(a_level), .TxD(a_txd), .TxD_busy(a_busy)
    );

    uart_tx_framer #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(b_valid), .tx_data(b_data),
        .tx_ready(b_ready), .tx_level(b_level), .TxD(b_txd), .TxD_busy(b_busy)
    );

    uart_tx_framer #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_valid(c_valid), .tx_data(c_data),
        .tx_ready(c_ready), .tx_level(c_level), .TxD(c_txd), .TxD_busy(c_busy)
    );

    always #5 clk = ~clk;

    // line level of a frame carrying 'word', 'el' clocks after its start bit began
    function automatic logic exp_bit(int word, int el, int db, int par);
        int idx = el / DIV;
        int ones = 0;
        for (int i = 0; i < db; i++) ones += (word >> i) & 1;
        if (idx == 0) return 1'b0;
        if (idx <= db) return 1'((word >> (idx - 1)) & 1);
        if (par != 0 && idx == db + 1) return (par == 2) ? 1'(ones % 2) : 1'(1 - (ones % 2));
        return 1'b1;
    endfunction

    // reference for instance A: a word queue plus the age of the frame on the line
    int q_a[$];
    int m_word = 0;
    bit m_active = 1'b0;
    int m_el = 0;
    bit m_can_push, m_do_pop;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q_a.delete();
                m_active = 1'b0;
                m_el = 0;
            end else begin
                m_can_push = (q_a.size() < 4);
                m_do_pop = (q_a.size() > 0) && (!m_active || m_el == FL_A - 1);
                if (m_active) begin
                    if (m_el == FL_A - 1) m_active = 1'b0;
                    else m_el++;
                end
                if (m_do_pop) begin
                    m_word = q_a.pop_front();
                    m_active = 1'b1;
                    m_el = 0;
                end
                if (a_valid && m_can_push) q_a.push_back(int'(a_data));
            end
        end
    end

    function automatic logic [5:0] model_vec();
        int sz = q_a.size();
        logic t = m_active ? exp_bit(m_word, m_el, 8, 0) : 1'b1;
        return {t, (m_active || sz > 0), (sz < 4), 3'(sz)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== 6'b101000 || b_vec !== 6'b101000 || c_vec !== 6'b101000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got a=%b b=%b c=%b exp=101000", n, a_vec, b_vec, c_vec);
            end
        end
    endtask

    task automatic test_single_8n1();
        logic       bits [130];
        logic [9:0] tbl = 10'b1101001010;
        int busy_cnt = 0;
        int fall = -1;
        a_valid = 1'b1;
        a_data = 8'hA5;
        @(negedge clk);
        a_valid = 1'b0;
        for (int idx = 0; idx < 130; idx++) begin
            if (idx > 0) @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL single_cycle idx=%0d got=%b exp=%b", idx, a_vec, model_vec());
            end
            if (a_busy) busy_cnt++;
            if (fall < 0 && a_txd === 1'b0) fall = idx;
            bits[idx] = a_txd;
        end
        checks++;
        if (fall !== 1) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=1", fall);
        end
        checks++;
        if (busy_cnt !== FL_A + 1) begin
            failures++;
            $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, FL_A + 1);
        end
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (bits[1 + b * DIV + DIV / 2] !== tbl[b]) begin
                failures++;
                $display("FAIL single_bit%0d got=%b exp=%b", b, bits[1 + b * DIV + DIV / 2], tbl[b]);
            end
        end
    endtask

    task automatic test_parity();
        int b_cnt = 0;
        int c_cnt = 0;
        logic b_par = 1'bx;
        logic c_par = 1'bx;
        logic eb, ec;
        b_valid = 1'b1; b_data = 7'h55;
        c_valid = 1'b1; c_data = 7'h55;
        @(negedge clk);
        b_valid = 1'b0;
        c_valid = 1'b0;
        for (int idx = 0; idx < 130; idx++) begin
            if (idx > 0) @(negedge clk);
            eb = (idx >= 1 && idx - 1 < FL_B) ? exp_bit(32'h55, idx - 1, 7, 2) : 1'b1;
            ec = (idx >= 1 && idx - 1 < FL_B) ? exp_bit(32'h55, idx - 1, 7, 1) : 1'b1;
            checks++;
            if (b_txd !== eb || c_txd !== ec) begin
                failures++;
                $display("FAIL parity_line idx=%0d got b=%b c=%b exp b=%b c=%b", idx, b_txd, c_txd, eb, ec);
            end
            if (b_busy) b_cnt++;
            if (c_busy) c_cnt++;
            if (idx == 1 + 8 * DIV + DIV / 2) begin
                b_par = b_txd;
                c_par = c_txd;
            end
        end
        checks++;
        if (b_par !== 1'b0 || c_par !== 1'b1) begin
            failures++;
            $display("FAIL parity_bit got even=%b odd=%b exp even=0 odd=1", b_par, c_par);
        end
        checks++;
        if (b_cnt !== FL_B + 1 || c_cnt !== FL_B + 1) begin
            failures++;
            $display("FAIL parity_busy_len got b=%0d c=%0d exp=%0d", b_cnt, c_cnt, FL_B + 1);
        end
    endtask

    task automatic test_fifo_full();
        int  next = 1;
        bit  saw_full = 1'b0;
        bit  acc;
        int  guard = 0;
        a_valid = 1'b1;
        a_data = 8'h00;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL full_lead got=%b exp=%b", a_vec, model_vec());
            end
        end
        a_valid = 1'b1;
        a_data = 8'(next);
        while (next <= 5 && guard < 400) begin
            acc = a_ready;
            if (acc && next == 5) begin
                checks++;
                if (a_level !== 3'd3) begin
                    failures++;
                    $display("FAIL full_fifth_after_pop got level=%0d exp=3", a_level);
                end
            end
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL full_cycle got=%b exp=%b", a_vec, model_vec());
            end
            if (a_level === 3'd4 && a_ready === 1'b0) saw_full = 1'b1;
            if (acc) begin
                next++;
                a_data = 8'(next);
            end
            guard++;
        end
        a_valid = 1'b0;
        checks++;
        if (next <= 5) begin
            failures++;
            $display("FAIL full_timeout got accepted=%0d exp=5", next - 1);
        end
        checks++;
        if (!saw_full) begin
            failures++;
            $display("FAIL full_stall got no_full_seen exp level=4 ready=0");
        end
        repeat (650) begin
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL full_drain got=%b exp=%b", a_vec, model_vec());
            end
        end
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL full_idle_end got busy=%b exp=0", a_busy);
        end
    endtask

    task automatic test_push_at_pop();
        int guard = 0;
        a_valid = 1'b1;
        a_data = 8'($urandom);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1;
            a_data = 8'($urandom);
            @(negedge clk);
        end
        a_data = 8'h99;
        while (!(m_active && m_el == FL_A - 1) && guard < 300) begin
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL pap_wait got=%b exp=%b", a_vec, model_vec());
            end
            guard++;
        end
        checks++;
        if (a_ready !== 1'b0 || a_level !== 3'd4) begin
            failures++;
            $display("FAIL pap_at_pop got ready=%b level=%0d exp ready=0 level=4", a_ready, a_level);
        end
        @(negedge clk);
        checks++;
        if (a_level !== 3'd3 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL pap_after_pop got ready=%b level=%0d exp ready=1 level=3", a_ready, a_level);
        end
        @(negedge clk);
        a_valid = 1'b0;
        checks++;
        if (a_level !== 3'd4) begin
            failures++;
            $display("FAIL pap_retry got level=%0d exp=4", a_level);
        end
        repeat (550) begin
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL pap_drain got=%b exp=%b", a_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1;
            a_data = 8'($urandom);
            @(negedge clk);
        end
        a_valid = 1'b0;
        while (!(m_active && m_el == 4 * DIV + DIV / 2) && guard < 200) begin
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL rmid_wait got=%b exp=%b", a_vec, model_vec());
            end
            guard++;
        end
        checks++;
        if (a_level !== 3'd2) begin
            failures++;
            $display("FAIL rmid_queued got level=%0d exp=2", a_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_txd !== 1'b1 || a_level !== 3'd0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got txd=%b level=%0d busy=%b exp 1 0 0", a_txd, a_level, a_busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            checks++;
            if (a_txd !== 1'b1 || a_vec !== model_vec()) begin
                failures++;
                $display("FAIL rmid_quiet cyc=%0d got=%b exp=%b", n, a_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            a_valid = ($urandom_range(0, 3) == 0);
            a_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL random_cycle n=%0d got=%b exp=%b", n, a_vec, model_vec());
            end
        end
        a_valid = 1'b0;
        repeat (600) begin
            @(negedge clk);
            checks++;
            if (a_vec !== model_vec()) begin
                failures++;
                $display("FAIL random_drain got=%b exp=%b", a_vec, model_vec());
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_8n1();
        test_parity();
        test_fifo_full();
        test_push_at_pop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
